// File: rtl/calc_all_axis_timings_pkg.sv
// Shared types and index constants for the speed/jerk/acc planner.
package speed_jerk_acc_pkg;

  localparam int unsigned NUM_AXES = 5;

  // Parameter word indices within axis_params_t
  localparam int unsigned PAR_STEPS  = 0;
  localparam int unsigned PAR_VSTART = 1;
  localparam int unsigned PAR_VMAX   = 2;
  localparam int unsigned PAR_ACC    = 3;
  localparam int unsigned PAR_JERK   = 4;

  // Result word indices within axis_timing_t
  localparam int unsigned TIM_ACC = 0;
  localparam int unsigned TIM_CRU = 1;
  localparam int unsigned TIM_DEC = 2;
  localparam int unsigned TIM_TOT = 3;

  typedef logic [0:4][31:0] axis_params_t;
  typedef logic [0:3][63:0] axis_timing_t;

  function automatic logic [63:0] max64(input logic [63:0] a, input logic [63:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/calc_all_axis_timings_axis.sv
// Single-axis timing engine: classifies the move, then runs up to three
// divisions through one shared restoring divider (one quotient bit per cycle).
module calc_axis_timing
  import speed_jerk_acc_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DIV_W  = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         abort,
  input  logic         eng_start,
  input  axis_params_t params,
  output axis_timing_t res,
  output logic         eng_done
);

  localparam int unsigned CW = $clog2(DIV_W);
  localparam logic [63:0] CLK64 = 64'(CLK_HZ);

  typedef enum logic [2:0] {E_IDLE, E_CLASS, E_DIV, E_POST, E_DONE} eng_state_t;
  typedef enum logic [1:0] {PH_ACC, PH_RAMP, PH_CRU} phase_t;

  eng_state_t st, st_nxt;
  phase_t     ph, ph_nxt;

  logic [63:0] steps, vs, vm, acc;
  logic [63:0] t_acc, t_cru;
  logic [DIV_W-1:0] div_rem, div_quo, div_den;
  logic [CW-1:0]    cnt;

  logic        ld_div, acc_wr, cru_wr;
  logic [63:0] ld_num, ld_den, acc_val, cru_val;
  logic [63:0] dv, q64, s2;
  logic [DIV_W:0] rem_sh;
  logic        rem_ge;

  // jerk is carried in the parameter record but plays no part in timing
  logic unused_jerk;
  assign unused_jerk = ^params[PAR_JERK];

  // Datapath helpers: ramp velocity delta, finished quotient, one divider step
  always_comb begin
    dv     = vm - vs;
    q64    = 64'(div_quo);
    s2     = q64 << 1;
    rem_sh = {div_rem, div_quo[DIV_W-1]};
    rem_ge = rem_sh >= {1'b0, div_den};
  end

  // Sequencing: classify, then chain acc -> ramp distance -> cruise divisions
  always_comb begin
    st_nxt  = st;
    ph_nxt  = ph;
    ld_div  = 1'b0;
    ld_num  = '0;
    ld_den  = '0;
    acc_wr  = 1'b0;
    cru_wr  = 1'b0;
    acc_val = '0;
    cru_val = '0;
    case (st)
      E_IDLE: if (eng_start) st_nxt = E_CLASS;
      E_CLASS: begin
        acc_wr = 1'b1;
        cru_wr = 1'b1;
        if (steps == '0 || vm == '0) begin
          st_nxt = E_DONE;
        end else if (vs >= vm || acc == '0) begin
          ld_div = 1'b1;
          ld_num = steps * CLK64;
          ld_den = vm;
          ph_nxt = PH_CRU;
          st_nxt = E_DIV;
        end else begin
          ld_div = 1'b1;
          ld_num = dv * CLK64;
          ld_den = acc;
          ph_nxt = PH_ACC;
          st_nxt = E_DIV;
        end
      end
      E_DIV: if (cnt == CW'(DIV_W - 1)) st_nxt = E_POST;
      E_POST: begin
        case (ph)
          PH_ACC: begin
            acc_wr  = 1'b1;
            acc_val = q64;
            ld_div  = 1'b1;
            ld_num  = (vs + vm) * dv;
            ld_den  = acc << 1;
            ph_nxt  = PH_RAMP;
            st_nxt  = E_DIV;
          end
          PH_RAMP: begin
            // q64 holds s_ramp; a move too short for both ramps gets no cruise
            if (s2 >= steps) begin
              cru_wr = 1'b1;
              st_nxt = E_DONE;
            end else begin
              ld_div = 1'b1;
              ld_num = (steps - s2) * CLK64;
              ld_den = vm;
              ph_nxt = PH_CRU;
              st_nxt = E_DIV;
            end
          end
          default: begin
            cru_wr  = 1'b1;
            cru_val = q64;
            st_nxt  = E_DONE;
          end
        endcase
      end
      E_DONE:  st_nxt = E_IDLE;
      default: st_nxt = E_IDLE;
    endcase
  end

  // State, parameter latch, divider iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= E_IDLE;
      ph      <= PH_ACC;
      steps   <= '0;
      vs      <= '0;
      vm      <= '0;
      acc     <= '0;
      t_acc   <= '0;
      t_cru   <= '0;
      div_rem <= '0;
      div_quo <= '0;
      div_den <= '0;
      cnt     <= '0;
    end else if (abort) begin
      st <= E_IDLE;
    end else begin
      st <= st_nxt;
      ph <= ph_nxt;
      if (st == E_IDLE && eng_start) begin
        steps <= 64'(params[PAR_STEPS]);
        vs    <= 64'(params[PAR_VSTART]);
        vm    <= 64'(params[PAR_VMAX]);
        acc   <= 64'(params[PAR_ACC]);
      end
      if (ld_div) begin
        div_rem <= '0;
        div_quo <= DIV_W'(ld_num);
        div_den <= DIV_W'(ld_den);
        cnt     <= '0;
      end else if (st == E_DIV) begin
        div_rem <= DIV_W'(rem_ge ? rem_sh - {1'b0, div_den} : rem_sh);
        div_quo <= {div_quo[DIV_W-2:0], rem_ge};
        cnt     <= cnt + 1'b1;
      end
      if (acc_wr) t_acc <= acc_val;
      if (cru_wr) t_cru <= cru_val;
    end
  end

  // Results stay valid after the done pulse until the next start
  always_comb begin
    res          = '0;
    res[TIM_ACC] = t_acc;
    res[TIM_CRU] = t_cru;
    res[TIM_DEC] = t_acc;
    res[TIM_TOT] = t_acc + t_cru + t_acc;
    eng_done     = (st == E_DONE);
  end

endmodule

// File: rtl/calc_all_axis_timings.sv
// Forward timing pass: sequences the five axes through one engine and keeps
// per-axis results plus their element-wise maximum.
module calc_all_axis_timings
  import speed_jerk_acc_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DIV_W  = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  axis_params_t params_x,
  input  axis_params_t params_y,
  input  axis_params_t params_z,
  input  axis_params_t params_e0,
  input  axis_params_t params_e1,
  output axis_timing_t timing_x,
  output axis_timing_t timing_y,
  output axis_timing_t timing_z,
  output axis_timing_t timing_e0,
  output axis_timing_t timing_e1,
  output axis_timing_t max_timing,
  output logic         finish
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_STORE, S_DONE} state_t;

  state_t       st, st_nxt;
  logic [2:0]   idx;
  axis_timing_t tim_q [NUM_AXES];
  axis_timing_t max_q;
  axis_params_t cur_params;
  axis_timing_t res;
  logic         eng_start, eng_done;

  calc_axis_timing #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) u_eng (
    .clk       (clk),
    .reset     (reset),
    .abort     (~start),
    .eng_start (eng_start),
    .params    (cur_params),
    .res       (res),
    .eng_done  (eng_done)
  );

  // Axis parameter mux
  always_comb begin
    case (idx)
      3'd0:    cur_params = params_x;
      3'd1:    cur_params = params_y;
      3'd2:    cur_params = params_z;
      3'd3:    cur_params = params_e0;
      default: cur_params = params_e1;
    endcase
  end

  // Next state; a low start aborts from any state
  always_comb begin
    st_nxt    = st;
    eng_start = 1'b0;
    if (!start) begin
      st_nxt = S_IDLE;
    end else begin
      case (st)
        S_IDLE: st_nxt = S_LOAD;
        S_LOAD: begin
          eng_start = 1'b1;
          st_nxt    = S_RUN;
        end
        S_RUN:   if (eng_done) st_nxt = S_STORE;
        S_STORE: st_nxt = (idx == 3'(NUM_AXES - 1)) ? S_DONE : S_LOAD;
        S_DONE:  st_nxt = S_DONE;
        default: st_nxt = S_IDLE;
      endcase
    end
  end

  // State register, axis index, result demux and max accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= S_IDLE;
      idx   <= '0;
      max_q <= '0;
      for (int unsigned a = 0; a < NUM_AXES; a++) tim_q[a] <= '0;
    end else begin
      st <= st_nxt;
      if (start && st == S_IDLE) begin
        idx   <= '0;
        max_q <= '0;
      end
      if (start && st == S_STORE) begin
        tim_q[idx] <= res;
        for (int unsigned k = 0; k < 4; k++) max_q[k] <= max64(max_q[k], res[k]);
        if (idx != 3'(NUM_AXES - 1)) idx <= idx + 3'd1;
      end
    end
  end

  // Output mapping
  always_comb begin
    timing_x   = tim_q[0];
    timing_y   = tim_q[1];
    timing_z   = tim_q[2];
    timing_e0  = tim_q[3];
    timing_e1  = tim_q[4];
    max_timing = max_q;
    finish     = (st == S_DONE);
  end

endmodule

// File: tb/tb_calc_all_axis_timings.sv
// Bench for calc_all_axis_timings: fixed vector table, abort/reset sequences
// and randomized runs against an arithmetic reference model.
module tb_calc_all_axis_timings;
  import speed_jerk_acc_pkg::*;

  localparam longint unsigned CLK = 50_000_000;
  localparam int MAX_WAIT = 5 * (3 * (64 + 2) + 4 + 3) + 2;

  typedef logic [0:NUM_AXES-1][0:4][31:0] all_params_t;
  typedef logic [0:NUM_AXES-1][0:3][63:0] all_timing_t;

  typedef struct {
    string        name;
    all_params_t  p;
    all_timing_t  e;
    axis_timing_t m;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, finish;
  axis_params_t params_x, params_y, params_z, params_e0, params_e1;
  axis_timing_t timing_x, timing_y, timing_z, timing_e0, timing_e1, max_timing;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  calc_all_axis_timings #(
    .CLK_HZ (50_000_000),
    .DIV_W  (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .params_x   (params_x),
    .params_y   (params_y),
    .params_z   (params_z),
    .params_e0  (params_e0),
    .params_e1  (params_e1),
    .timing_x   (timing_x),
    .timing_y   (timing_y),
    .timing_z   (timing_z),
    .timing_e0  (timing_e0),
    .timing_e1  (timing_e1),
    .max_timing (max_timing),
    .finish     (finish)
  );

  function automatic axis_params_t mkp(int unsigned s, int unsigned vs, int unsigned vm, int unsigned a);
    axis_params_t p;
    p = '0;
    p[PAR_STEPS]  = s;
    p[PAR_VSTART] = vs;
    p[PAR_VMAX]   = vm;
    p[PAR_ACC]    = a;
    return p;
  endfunction

  function automatic axis_timing_t mkt(longint unsigned ta, longint unsigned tc, longint unsigned td, longint unsigned tt);
    axis_timing_t t;
    t[TIM_ACC] = ta;
    t[TIM_CRU] = tc;
    t[TIM_DEC] = td;
    t[TIM_TOT] = tt;
    return t;
  endfunction

  // Reference: the planner's timing rules as plain 64-bit arithmetic
  function automatic axis_timing_t model(axis_params_t p);
    longint unsigned s, vs, vm, a, dv, ta, tc, sr;
    s  = 64'(p[PAR_STEPS]);
    vs = 64'(p[PAR_VSTART]);
    vm = 64'(p[PAR_VMAX]);
    a  = 64'(p[PAR_ACC]);
    ta = 0;
    tc = 0;
    if (s != 0 && vm != 0) begin
      if (vs >= vm || a == 0) begin
        tc = s * CLK / vm;
      end else begin
        dv = vm - vs;
        ta = dv * CLK / a;
        sr = (vs + vm) * dv / (2 * a);
        if (2 * sr < s) tc = (s - 2 * sr) * CLK / vm;
      end
    end
    return mkt(ta, tc, ta, ta + tc + ta);
  endfunction

  function automatic axis_timing_t dut_t(int a);
    case (a)
      0:       return timing_x;
      1:       return timing_y;
      2:       return timing_z;
      3:       return timing_e0;
      default: return timing_e1;
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic set_params(all_params_t p);
    params_x  = p[0];
    params_y  = p[1];
    params_z  = p[2];
    params_e0 = p[3];
    params_e1 = p[4];
  endtask

  task automatic expect_from_model(all_params_t p, output all_timing_t e, output axis_timing_t m);
    axis_timing_t t;
    m = '0;
    for (int a = 0; a < NUM_AXES; a++) begin
      t = model(p[a]);
      e[a] = t;
      for (int k = 0; k < 4; k++) if (t[k] > m[k]) m[k] = t[k];
    end
  endtask

  task automatic chk_outputs(string tag, all_timing_t e, axis_timing_t m);
    axis_timing_t t;
    for (int a = 0; a < NUM_AXES; a++) begin
      t = dut_t(a);
      for (int k = 0; k < 4; k++) chk($sformatf("%s.ax%0d.t%0d", tag, a, k), t[k], e[a][k]);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("%s.max%0d", tag, k), max_timing[k], m[k]);
  endtask

  task automatic wait_finish(string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      if (finish) begin
        ok = 1;
        break;
      end
    end
    chk({tag, ".finish_in_time"}, 64'(ok), 64'd1);
  endtask

  // Full run: start, wait for finish, compare, check hold, then drop start
  task automatic run_and_check(string tag, all_params_t p, all_timing_t e, axis_timing_t m);
    axis_timing_t held;
    set_params(p);
    start = 1'b1;
    wait_finish(tag);
    chk_outputs(tag, e, m);
    held = timing_x;
    repeat (3) @(negedge clk);
    chk({tag, ".finish_hold"}, 64'(finish), 64'd1);
    chk({tag, ".x_hold"}, held[TIM_TOT], e[0][TIM_TOT]);
    start = 1'b0;
    @(negedge clk);
    chk({tag, ".finish_clear"}, 64'(finish), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    vec_t         vecs[$];
    vec_t         v;
    axis_params_t t1p, zp;
    axis_timing_t e1, e2, z4;
    all_params_t  p;
    all_timing_t  e;
    axis_timing_t m;
    bit           ok;

    reset = 1'b1;
    start = 1'b0;
    set_params('0);

    t1p = mkp(1000, 0, 1000, 1000);
    zp  = mkp(0, 0, 1000, 1000);
    e1  = mkt(50_000_000, 0, 50_000_000, 100_000_000);
    e2  = mkt(50_000_000, 100_000_000, 50_000_000, 200_000_000);
    z4  = '0;

    v.name = "all_equal";
    for (int a = 0; a < NUM_AXES; a++) begin v.p[a] = t1p; v.e[a] = e1; end
    v.m = e1;
    vecs.push_back(v);

    v.name = "x_cruise";
    for (int a = 0; a < NUM_AXES; a++) begin v.p[a] = zp; v.e[a] = z4; end
    v.p[0] = mkp(3000, 0, 1000, 1000); v.e[0] = e2;
    v.m = e2;
    vecs.push_back(v);

    v.name = "y_const";
    v.p[1] = mkp(500, 2000, 1000, 1000);
    v.e[1] = mkt(0, 25_000_000, 0, 25_000_000);
    v.m = e2;
    vecs.push_back(v);

    v.name = "zero_axes";
    v.p[0] = mkp(1000, 0, 0, 1000);    v.e[0] = z4;
    v.p[1] = t1p;                      v.e[1] = e1;
    v.p[2] = mkp(2000, 0, 1000, 0);    v.e[2] = mkt(0, 100_000_000, 0, 100_000_000);
    v.p[3] = t1p;                      v.e[3] = e1;
    v.p[4] = zp;                       v.e[4] = z4;
    v.m = mkt(50_000_000, 100_000_000, 50_000_000, 100_000_000);
    vecs.push_back(v);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset.finish", 64'(finish), 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset.x%0d", k), timing_x[k], 64'd0);
      chk($sformatf("reset.max%0d", k), max_timing[k], 64'd0);
    end

    // Directed table
    foreach (vecs[i]) run_and_check(vecs[i].name, vecs[i].p, vecs[i].e, vecs[i].m);

    // Abort during z, then restart with changed x parameters
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < NUM_AXES; a++) p[a] = t1p;
    set_params(p);
    start = 1'b1;
    ok = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      if (timing_y[TIM_TOT] != 0) begin ok = 1; break; end
    end
    chk("abort.y_stored", 64'(ok), 64'd1);
    repeat (30) @(negedge clk);
    chk("abort.z_pending", timing_z[TIM_TOT], 64'd0);
    start = 1'b0;
    @(negedge clk);
    chk("abort.finish", 64'(finish), 64'd0);
    chk("abort.x_held", timing_x[TIM_TOT], e1[TIM_TOT]);
    chk("abort.y_held", timing_y[TIM_ACC], e1[TIM_ACC]);
    chk("abort.max_held", max_timing[TIM_TOT], e1[TIM_TOT]);
    p[0] = mkp(3000, 0, 1000, 1000);
    set_params(p);
    start = 1'b1;
    @(negedge clk);
    chk("abort.restart_finish", 64'(finish), 64'd0);
    expect_from_model(p, e, m);
    wait_finish("abort");
    chk_outputs("abort", e, m);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // One-cycle reset in the middle of a run with start held high
    p = vecs[2].p;
    set_params(p);
    start = 1'b1;
    repeat (300) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst.finish", 64'(finish), 64'd0);
    chk_outputs("rst", '0, '0);
    wait_finish("rst");
    chk_outputs("rst_run", vecs[2].e, vecs[2].m);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < NUM_AXES; a++) begin
        p[a] = mkp(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 200000),
                   $urandom_range(0, 30000),
                   ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40000),
                   ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 500000));
        p[a][PAR_JERK] = $urandom;
      end
      expect_from_model(p, e, m);
      run_and_check($sformatf("rand%0d", r), p, e, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
